// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 keyboard front end:
//   - frame_state_t : serial frame receiver states
//   - PS2_EXT/PS2_BRK : set-2 extended and break prefix bytes
//   - SC_*  : set-2 scan codes of the keys the game cares about
//   - KEY_* : HID usage codes driven on the keycode bus
//   - ps2_to_hid() : {ext, scan code} -> HID code, KEY_NONE if unmapped
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    // Set-2 scan codes (arrow keys arrive behind an E0 prefix)
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // HID usage codes
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // The ext flag is part of the lookup key: 75 alone is keypad-8,
    // which the game does not use, while E0 75 is the up arrow.
    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        case ({ext, code})
            {1'b0, SC_A}:     hid = KEY_A;
            {1'b0, SC_D}:     hid = KEY_D;
            {1'b0, SC_S}:     hid = KEY_S;
            {1'b0, SC_W}:     hid = KEY_W;
            {1'b0, SC_SPACE}: hid = KEY_SPACE;
            {1'b1, SC_UP}:    hid = KEY_UP;
            {1'b1, SC_DOWN}:  hid = KEY_DOWN;
            {1'b1, SC_LEFT}:  hid = KEY_LEFT;
            {1'b1, SC_RIGHT}: hid = KEY_RIGHT;
            default:          hid = KEY_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Byte-level PS/2 receiver: 2-FF synchronizers on both pins, a glitch
//   filter on the keyboard clock, the 11-bit frame FSM (start, 8 data LSB
//   first, odd parity, stop) and an inactivity timeout for stalled frames.
// Parameters:
//   FILTER_LEN     - equal synchronized samples before the filtered clock moves
//   TIMEOUT_CYCLES - Clk cycles without a bit strobe mid-frame before abort
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-low reset
//   PS2_CLK    in   raw keyboard clock (asynchronous)
//   PS2_DATA   in   raw keyboard data (asynchronous)
//   rx_byte    out  last correctly received byte
//   byte_valid out  one-cycle pulse, the cycle after a good stop bit
//   frame_err  out  one-cycle pulse on start/parity/stop error or timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------------------------------------------------------
    // Synchronizers: bit 0 = keyboard clock, bit 1 = keyboard data.
    // Both idle high, so reset to 1 to avoid a false edge at startup.
    // ---------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {PS2_DATA, PS2_CLK};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Clock filter: the filtered level only follows the synchronized
    // clock once the last FILTER_LEN samples all agree.
    // ---------------------------------------------------------------
    logic [FILTER_LEN-1:0] hist_reg;
    logic                  clk_filt_reg;
    logic                  clk_filt_next;
    logic                  strobe_reg;

    always_comb begin
        clk_filt_next = clk_filt_reg;
        if (&hist_reg) begin
            clk_filt_next = 1'b1;
        end else if (~|hist_reg) begin
            clk_filt_next = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hist_reg     <= {FILTER_LEN{1'b1}};
            clk_filt_reg <= 1'b1;
            strobe_reg   <= 1'b0;
        end else begin
            hist_reg     <= {hist_reg[FILTER_LEN-2:0], pin_sync[0]};
            clk_filt_reg <= clk_filt_next;
            // Falling edge of the filtered clock; data is long settled by
            // now since the keyboard holds it across the whole low phase.
            strobe_reg   <= clk_filt_reg & ~clk_filt_next;
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    frame_state_t    state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_reg, parity_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [7:0]      rx_byte_reg, rx_byte_next;
    logic            byte_valid_reg, byte_valid_next;
    logic            frame_err_reg, frame_err_next;
    logic            data_bit;

    assign data_bit = pin_sync[1];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            rx_byte_reg    <= 8'h00;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            to_cnt_reg     <= to_cnt_next;
            rx_byte_reg    <= rx_byte_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        to_cnt_next     = to_cnt_reg;
        rx_byte_next    = rx_byte_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                to_cnt_next = '0;
                if (strobe_reg) begin
                    if (!data_bit) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        // A clock pulse without a start bit: out of sync
                        frame_err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (strobe_reg) begin
                    shift_next   = {data_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (strobe_reg) begin
                    parity_next = data_bit;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (strobe_reg) begin
                    if (data_bit && (^{shift_reg, parity_reg})) begin
                        rx_byte_next    = shift_reg;
                        byte_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Inactivity watchdog; restarts on every bit so only a stalled
        // frame can expire. Never coincides with a strobe.
        if (state_reg != IDLE) begin
            if (strobe_reg) begin
                to_cnt_next = '0;
            end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_next    = '0;
                state_next     = IDLE;
                frame_err_next = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    assign rx_byte    = rx_byte_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   Keyboard front end feeding the tank/ball motion logic. Receives PS/2
//   set-2 bytes, tracks E0/F0 prefixes and translates movement/fire keys
//   into HID codes on the keycode bus.
// Build option:
//   PS2_KEY_ROLLOVER_EN - when defined, keeps two held keys; releasing the
//                         newest falls back to the older one. Undefined:
//                         single-key behaviour.
// Parameters:
//   FILTER_LEN, TIMEOUT_CYCLES - passed to the frame receiver
// Ports:
//   Clk       in   system clock
//   Reset     in   synchronous, active-low reset
//   PS2_CLK   in   raw keyboard clock (asynchronous)
//   PS2_DATA  in   raw keyboard data (asynchronous)
//   keycode   out  HID code of the currently held mapped key, 0x00 if none
//   key_event out  one-cycle pulse whenever keycode changes
//   frame_err out  one-cycle pulse on a bad or timed-out frame
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    logic       ext_reg, ext_next;
    logic       brk_reg, brk_next;
    logic [7:0] keycode_reg, keycode_next;
    logic       key_event_reg, key_event_next;
    logic [7:0] hid;
`ifdef PS2_KEY_ROLLOVER_EN
    // keycode_reg holds the newest held key, older_reg the one before it
    logic [7:0] older_reg, older_next;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            keycode_reg   <= KEY_NONE;
            key_event_reg <= 1'b0;
`ifdef PS2_KEY_ROLLOVER_EN
            older_reg     <= KEY_NONE;
`endif
        end else begin
            ext_reg       <= ext_next;
            brk_reg       <= brk_next;
            keycode_reg   <= keycode_next;
            key_event_reg <= key_event_next;
`ifdef PS2_KEY_ROLLOVER_EN
            older_reg     <= older_next;
`endif
        end
    end

    always_comb begin
        ext_next     = ext_reg;
        brk_next     = brk_reg;
        keycode_next = keycode_reg;
`ifdef PS2_KEY_ROLLOVER_EN
        older_next   = older_reg;
`endif
        hid          = ps2_to_hid(ext_reg, rx_byte);

        if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_next = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_next = 1'b1;
            end else begin
                // Any key byte terminates the prefix sequence, mapped or not
                ext_next = 1'b0;
                brk_next = 1'b0;
                if (hid != KEY_NONE) begin
`ifdef PS2_KEY_ROLLOVER_EN
                    if (brk_reg) begin
                        if (hid == keycode_reg) begin
                            keycode_next = older_reg;
                            older_next   = KEY_NONE;
                        end else if (hid == older_reg) begin
                            older_next = KEY_NONE;
                        end
                    end else if (hid != keycode_reg) begin
                        // Newest moves down; whatever was older drops out.
                        // Re-pressing the older key simply swaps the two.
                        older_next   = keycode_reg;
                        keycode_next = hid;
                    end
`else
                    if (brk_reg) begin
                        if (hid == keycode_reg) begin
                            keycode_next = KEY_NONE;
                        end
                    end else begin
                        keycode_next = hid;
                    end
`endif
                end
            end
        end

        // Typematic repeats leave keycode unchanged and so raise no event
        key_event_next = (keycode_next != keycode_reg);
    end

    assign keycode   = keycode_reg;
    assign key_event = key_event_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

    localparam int TB_TIMEOUT = 600;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int ev_cnt       = 0;
    int err_cnt      = 0;
    int ev0, err0;

    always #5 Clk = ~Clk;

    ps2_keycode_rx #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .keycode  (keycode),
        .key_event(key_event),
        .frame_err(frame_err)
    );

    // Pulse counters sampled on the inactive edge
    always @(negedge Clk) begin
        if (key_event) ev_cnt <= ev_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        PS2_DATA = b;
        repeat (4) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (8) @(negedge Clk);
        PS2_CLK = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        PS2_DATA = 1'b1;
        repeat (12) @(negedge Clk);
        $display("[TB] frame 0x%02h par_err=%0d stop_err=%0d -> keycode 0x%02h",
                 b, bad_par, bad_stop, keycode);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic snap();
        ev0  = ev_cnt;
        err0 = err_cnt;
    endtask

    // Arrow/space table: ext flag, scan code, expected HID
    logic [7:0] tbl_sc  [4] = '{8'h29, 8'h72, 8'h6B, 8'h74};
    logic       tbl_ext [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] tbl_hid [4] = '{8'h2C, 8'h51, 8'h50, 8'h4F};

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        check_eq("reset_keycode", keycode, 8'h00);
        check_eq("reset_key_event", key_event, 0);
        check_eq("reset_frame_err", frame_err, 0);
        check_eq("reset_no_err_pulse", err_cnt, 0);

        // Make/break A
        snap(); key(8'h1C);
        check_eq("make_A", keycode, 8'h04);
        check_eq("make_A_evt", ev_cnt - ev0, 1);
        check_eq("make_A_noerr", err_cnt - err0, 0);
        snap(); key(8'hF0); key(8'h1C);
        check_eq("brk_A", keycode, 8'h00);
        check_eq("brk_A_evt", ev_cnt - ev0, 1);

        // Extended up arrow
        snap(); key(8'hE0); key(8'h75);
        check_eq("make_up", keycode, 8'h52);
        check_eq("make_up_evt", ev_cnt - ev0, 1);
        snap(); key(8'hE0); key(8'hF0); key(8'h75);
        check_eq("brk_up", keycode, 8'h00);
        check_eq("brk_up_evt", ev_cnt - ev0, 1);
        snap(); key(8'h75);
        check_eq("plain_75_ignored", keycode, 8'h00);
        check_eq("plain_75_noevt", ev_cnt - ev0, 0);
        key(8'h1C);
        check_eq("flags_clear_make_A", keycode, 8'h04);
        key(8'hF0); key(8'h1C);
        check_eq("flags_clear_brk_A", keycode, 8'h00);

        // Space and remaining arrows
        for (int i = 0; i < 4; i++) begin
            if (tbl_ext[i]) key(8'hE0);
            key(tbl_sc[i]);
            check_eq("tbl_make", keycode, tbl_hid[i]);
            if (tbl_ext[i]) key(8'hE0);
            key(8'hF0); key(tbl_sc[i]);
            check_eq("tbl_brk", keycode, 8'h00);
        end

        // Parity error then good W
        snap(); send_frame(8'h1D, 1'b1, 1'b0);
        check_eq("par_err_pulse", err_cnt - err0, 1);
        check_eq("par_err_keycode", keycode, 8'h00);
        check_eq("par_err_noevt", ev_cnt - ev0, 0);
        snap(); key(8'h1D);
        check_eq("make_W", keycode, 8'h1A);
        check_eq("make_W_noerr", err_cnt - err0, 0);

        // Timeout after 4 data bits
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TB_TIMEOUT - 20) @(negedge Clk);
        check_eq("timeout_not_early", err_cnt - err0, 0);
        repeat (50) @(negedge Clk);
        $display("[TB] stalled frame, frame_err pulses %0d", err_cnt - err0);
        check_eq("timeout_pulse", err_cnt - err0, 1);
        check_eq("timeout_keycode", keycode, 8'h1A);
        key(8'h23);
        check_eq("after_timeout_D", keycode, 8'h07);

        // Typematic repeat and break of a non-current key
        snap(); key(8'h23);
        check_eq("repeat_D", keycode, 8'h07);
        check_eq("repeat_noevt", ev_cnt - ev0, 0);
        key(8'hF0); key(8'h1C);
        check_eq("brk_other", keycode, 8'h07);
        check_eq("brk_other_noevt", ev_cnt - ev0, 0);

        // Start-bit and stop-bit errors
        snap(); send_bit(1'b1); repeat (10) @(negedge Clk);
        $display("[TB] lone clock pulse, frame_err pulses %0d", err_cnt - err0);
        check_eq("start_err", err_cnt - err0, 1);
        snap(); send_frame(8'h1B, 1'b0, 1'b1);
        check_eq("stop_err", err_cnt - err0, 1);
        check_eq("stop_err_keycode", keycode, 8'h07);

        // Reset mid-frame discards prefix and partial byte
        key(8'h1B);
        check_eq("make_S", keycode, 8'h16);
        key(8'hE0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        snap();
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        repeat (5) @(negedge Clk);
        $display("[TB] mid-frame reset -> keycode 0x%02h", keycode);
        check_eq("midreset_keycode", keycode, 8'h00);
        check_eq("midreset_noevt", ev_cnt - ev0, 0);
        key(8'h75);
        check_eq("midreset_ext_cleared", keycode, 8'h00);
        check_eq("midreset_noerr", err_cnt - err0, 0);
        key(8'h1B);
        check_eq("resume_S", keycode, 8'h16);
        key(8'hF0); key(8'h1B);
        check_eq("brk_S", keycode, 8'h00);

        // Two held keys
        snap();
        key(8'h1C); key(8'h23);
        check_eq("two_make", keycode, 8'h07);
        key(8'hF0); key(8'h23);
`ifdef PS2_KEY_ROLLOVER_EN
        check_eq("brk_newest", keycode, 8'h04);
`else
        check_eq("brk_newest", keycode, 8'h00);
`endif
        key(8'hF0); key(8'h1C);
        check_eq("brk_oldest", keycode, 8'h00);
`ifdef PS2_KEY_ROLLOVER_EN
        check_eq("rollover_evts", ev_cnt - ev0, 4);
`else
        check_eq("rollover_evts", ev_cnt - ev0, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
